// File: rtl/twiddle_pkg.sv
// Shared sizing constants and FSM state encoding for the twiddle fetch controller.
package twiddle_pkg;
  localparam int ADDR_W       = 5;
  localparam int DATA_W       = 16;
  localparam int NUM_STAGES   = 7;
  localparam int TW_PER_STAGE = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;
endpackage

// File: rtl/twiddle_skid_fifo.sv
// Small register-based FIFO that absorbs ROM read data while the consumer stalls.
module twiddle_skid_fifo #(
  parameter int WIDTH = 33,
  parameter int DEPTH = 2,
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count
);
  logic [WIDTH-1:0] mem_reg [DEPTH];
  logic [PTR_W-1:0] wr_ptr_reg;
  logic [PTR_W-1:0] rd_ptr_reg;
  logic [CNT_W-1:0] count_reg;
  logic [DEPTH-1:0] wr_en;
  logic             do_push;
  logic             do_pop;

  assign do_pop  = pop && !empty;
  // A full buffer may still accept a write when its head leaves in the same cycle.
  assign do_push = push && (!full || do_pop);

  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_wr_en
      assign wr_en[gi] = do_push && (wr_ptr_reg == PTR_W'(gi));
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_reg[i] <= '0;
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (wr_en[i]) mem_reg[i] <= push_data;
      end
      if (do_push) wr_ptr_reg <= (wr_ptr_reg == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr_reg + PTR_W'(1);
      if (do_pop)  rd_ptr_reg <= (rd_ptr_reg == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr_reg + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count_reg <= count_reg + CNT_W'(1);
        2'b01:   count_reg <= count_reg - CNT_W'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

  assign pop_data = mem_reg[rd_ptr_reg];
  assign full     = (count_reg == CNT_W'(DEPTH));
  assign empty    = (count_reg == '0);
  assign count    = count_reg;
endmodule

// File: rtl/twiddle_fetch_ctrl.sv
// Issues one stage's twiddle ROM reads and streams the returned pairs out
// over a valid/ready interface, throttled by a 2-entry buffer.
module twiddle_fetch_ctrl #(
  parameter int ADDR_W       = twiddle_pkg::ADDR_W,
  parameter int DATA_W       = twiddle_pkg::DATA_W,
  parameter int NUM_STAGES   = twiddle_pkg::NUM_STAGES,
  parameter int TW_PER_STAGE = twiddle_pkg::TW_PER_STAGE
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [2:0]        stage,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [DATA_W-1:0] rom_re,
  input  logic [DATA_W-1:0] rom_im,
  output logic [DATA_W-1:0] tw_re,
  output logic [DATA_W-1:0] tw_im,
  output logic              tw_valid,
  input  logic              tw_ready,
  output logic              tw_last,
  output logic              busy,
  output logic              done,
  output logic              err
);
  import twiddle_pkg::*;

  localparam int K_W = $clog2(TW_PER_STAGE);
  localparam int FW  = 2 * DATA_W + 1;

  state_t            state_reg;
  logic [2:0]        stage_reg;
  logic [K_W-1:0]    k_reg;
  logic [ADDR_W-1:0] addr_reg;
  logic              inflight_reg;
  logic              inflight_last_reg;
  logic              busy_reg;
  logic              done_reg;
  logic              err_reg;

  logic [FW-1:0]     head_data;
  logic              fifo_full;
  logic              fifo_empty;
  logic [1:0]        fifo_count;
  logic              unused_full;
  logic              pop;
  logic              issue;
  logic              k_last;
  logic [2:0]        occ_sum;

  assign pop     = tw_valid && tw_ready;
  assign k_last  = (k_reg == K_W'(TW_PER_STAGE - 1));
  assign occ_sum = 3'(fifo_count) + 3'(inflight_reg);
  // Credit check: buffered + returning pairs, minus the one leaving now, must stay below 2.
  assign issue   = (state_reg == ST_FETCH) && (occ_sum < (3'd2 + 3'(pop)));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg         <= ST_IDLE;
      stage_reg         <= '0;
      k_reg             <= '0;
      addr_reg          <= '0;
      inflight_reg      <= 1'b0;
      inflight_last_reg <= 1'b0;
      busy_reg          <= 1'b0;
      done_reg          <= 1'b0;
      err_reg           <= 1'b0;
    end else begin
      done_reg          <= 1'b0;
      err_reg           <= 1'b0;
      inflight_reg      <= issue;
      inflight_last_reg <= issue && k_last;
      case (state_reg)
        ST_IDLE: begin
          if (start) begin
            if (32'(stage) < NUM_STAGES) begin
              stage_reg <= stage;
              k_reg     <= '0;
              addr_reg  <= ADDR_W'({stage, {K_W{1'b0}}});
              busy_reg  <= 1'b1;
              state_reg <= ST_FETCH;
            end else begin
              err_reg <= 1'b1;
            end
          end
        end
        ST_FETCH: begin
          if (issue) begin
            k_reg <= k_reg + K_W'(1);
            if (k_last) state_reg <= ST_DRAIN;
            else        addr_reg  <= ADDR_W'({stage_reg, k_reg + K_W'(1)});
          end
        end
        ST_DRAIN: begin
          if (pop && tw_last) begin
            state_reg <= ST_IDLE;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b1;
          end
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  twiddle_skid_fifo #(
    .WIDTH(FW),
    .DEPTH(2)
  ) u_skid_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (inflight_reg),
    .push_data({inflight_last_reg, rom_re, rom_im}),
    .pop      (pop),
    .pop_data (head_data),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .count    (fifo_count)
  );

  assign unused_full = fifo_full;

  assign rom_addr = addr_reg;
  assign tw_valid = !fifo_empty;
  assign tw_last  = tw_valid && head_data[FW-1];
  assign tw_re    = tw_valid ? head_data[2*DATA_W-1:DATA_W] : '0;
  assign tw_im    = tw_valid ? head_data[DATA_W-1:0]        : '0;
  assign busy     = busy_reg;
  assign done     = done_reg;
  assign err      = err_reg;
endmodule

// File: tb/tb_twiddle_fetch_ctrl.sv
// Bench for twiddle_fetch_ctrl: directed scenarios plus random traffic, all
// compared against a transaction-level model of expected pairs and pulses.
module tb_twiddle_fetch_ctrl;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [2:0]  stage;
  logic [4:0]  rom_addr;
  logic [15:0] rom_re;
  logic [15:0] rom_im;
  logic [15:0] tw_re;
  logic [15:0] tw_im;
  logic        tw_valid;
  logic        tw_ready;
  logic        tw_last;
  logic        busy;
  logic        done;
  logic        err;

  typedef struct packed {
    logic        last;
    logic [15:0] re;
    logic [15:0] im;
  } pair_t;

  logic [15:0] re_vals [8][4];
  logic [15:0] rom_re_tbl [32];
  logic [15:0] rom_im_tbl [32];

  pair_t       exp_q [$];
  bit          idle_m;
  bit          exp_busy;
  bit          exp_done;
  bit          exp_err;
  bit          prev_stall;
  logic [15:0] prev_re;
  logic [15:0] prev_im;
  int          pops_seen;
  int          n_cmp = 0;
  int          n_mis = 0;

  always #5 clk = ~clk;

  twiddle_fetch_ctrl dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .stage   (stage),
    .rom_addr(rom_addr),
    .rom_re  (rom_re),
    .rom_im  (rom_im),
    .tw_re   (tw_re),
    .tw_im   (tw_im),
    .tw_valid(tw_valid),
    .tw_ready(tw_ready),
    .tw_last (tw_last),
    .busy    (busy),
    .done    (done),
    .err     (err)
  );

  // Synchronous-read twiddle ROMs living outside the controller.
  always @(posedge clk) begin
    rom_re <= rom_re_tbl[rom_addr];
    rom_im <= rom_im_tbl[rom_addr];
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    idle_m     = 1'b1;
    exp_busy   = 1'b0;
    exp_done   = 1'b0;
    exp_err    = 1'b0;
    prev_stall = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_valid"}, 64'(tw_valid), 64'd0);
    check_eq({tag, "_last"},  64'(tw_last),  64'd0);
    check_eq({tag, "_busy"},  64'(busy),     64'd0);
    check_eq({tag, "_done"},  64'(done),     64'd0);
    check_eq({tag, "_err"},   64'(err),      64'd0);
    check_eq({tag, "_addr"},  64'(rom_addr), 64'd0);
    check_eq({tag, "_re"},    64'(tw_re),    64'd0);
    check_eq({tag, "_im"},    64'(tw_im),    64'd0);
  endtask

  // One clock cycle: drive inputs after the falling edge, then check the
  // settled outputs and advance the model to what the next rising edge does.
  task automatic step(input bit st, input logic [2:0] sg, input bit rdy);
    pair_t e;
    bit    pop_now;
    bit    last_pop;
    @(negedge clk);
    start    = st;
    stage    = sg;
    tw_ready = rdy;
    #1;
    check_eq("busy", 64'(busy), 64'(exp_busy));
    check_eq("done", 64'(done), 64'(exp_done));
    check_eq("err",  64'(err),  64'(exp_err));
    if (prev_stall) begin
      check_eq("hold_valid", 64'(tw_valid), 64'd1);
      check_eq("hold_re",    64'(tw_re),    64'(prev_re));
      check_eq("hold_im",    64'(tw_im),    64'(prev_im));
    end
    if (exp_q.size() == 0) check_eq("idle_valid", 64'(tw_valid), 64'd0);
    pop_now  = tw_valid && rdy;
    last_pop = 1'b0;
    if (pop_now && exp_q.size() != 0) begin
      e = exp_q.pop_front();
      check_eq("pop_re",   64'(tw_re),   64'(e.re));
      check_eq("pop_im",   64'(tw_im),   64'(e.im));
      check_eq("pop_last", 64'(tw_last), 64'(e.last));
      pops_seen++;
      last_pop = e.last;
    end
    exp_err  = idle_m && st && (sg >= 3'd7);
    exp_done = last_pop;
    if (idle_m && st && (sg < 3'd7)) begin
      for (int k = 0; k < 4; k++) begin
        e.last = (k == 3);
        e.re   = rom_re_tbl[int'(sg) * 4 + k];
        e.im   = rom_im_tbl[int'(sg) * 4 + k];
        exp_q.push_back(e);
      end
      idle_m    = 1'b0;
      pops_seen = 0;
    end
    if (last_pop) idle_m = 1'b1;
    exp_busy   = !idle_m;
    prev_stall = tw_valid && !rdy;
    prev_re    = tw_re;
    prev_im    = tw_im;
  endtask

  // mode 0: always ready, 1: ready toggles 1/0, 2: random ready
  task automatic run_until_idle(input int max_cyc, input int mode);
    bit rdy;
    for (int c = 0; c < max_cyc && !(idle_m && exp_q.size() == 0); c++) begin
      case (mode)
        0:       rdy = 1'b1;
        1:       rdy = (c % 2 == 0);
        default: rdy = ($urandom_range(0, 2) != 0);
      endcase
      step(1'b0, 3'd0, rdy);
    end
    check_eq("drain_timeout", 64'(exp_q.size()), 64'd0);
  endtask

  task automatic release_reset();
    @(posedge clk);
    #2 rst_n = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    re_vals = '{'{16'h0100, 16'h0000, 16'hFF00, 16'h0000},
                '{16'h0100, 16'h0100, 16'h0100, 16'h0100},
                '{16'h0100, 16'h00B5, 16'h0000, 16'hFF4A},
                '{16'h0100, 16'h00ED, 16'h00B5, 16'h0062},
                '{16'h0100, 16'h00FB, 16'h00EC, 16'h00D4},
                '{16'h0100, 16'h00FE, 16'h00FB, 16'h00F5},
                '{16'h0100, 16'h00FF, 16'h00FE, 16'h00FD},
                '{16'h7777, 16'h7777, 16'h7777, 16'h7777}};
    for (int a = 0; a < 32; a++) begin
      rom_re_tbl[a] = re_vals[a / 4][a % 4];
      rom_im_tbl[a] = 16'(32'hC000 ^ (a * 291));
    end

    rst_n    = 1'b0;
    start    = 1'b0;
    stage    = 3'd0;
    tw_ready = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    check_reset_outputs("por");
    release_reset();

    // Bad stage right after reset: err pulse, no address, stays idle.
    step(1'b1, 3'd7, 1'b1);
    step(1'b0, 3'd0, 1'b1);
    check_eq("bad_stage_addr", 64'(rom_addr), 64'd0);
    step(1'b0, 3'd0, 1'b1);

    // Stage 2 with ready held: address sequence, latency and back-to-back pops.
    step(1'b1, 3'd2, 1'b1);
    for (int i = 1; i <= 7; i++) begin
      step(1'b0, 3'd0, 1'b1);
      if (i <= 4) check_eq("s2_addr", 64'(rom_addr), 64'(8 + i - 1));
      if (i == 2) check_eq("s2_latency", 64'(tw_valid), 64'd0);
      if (i >= 3 && i <= 6) check_eq("s2_stream", 64'(tw_valid), 64'd1);
    end

    // Stage 6 with ready toggling every cycle.
    step(1'b1, 3'd6, 1'b1);
    run_until_idle(40, 1);
    step(1'b0, 3'd0, 1'b1);

    // Stage 4 stalled for 10 cycles: only two reads may be issued.
    step(1'b1, 3'd4, 1'b0);
    repeat (10) step(1'b0, 3'd0, 1'b0);
    check_eq("stall_addr",  64'(rom_addr), 64'd18);
    check_eq("stall_valid", 64'(tw_valid), 64'd1);
    run_until_idle(40, 0);
    step(1'b0, 3'd0, 1'b1);

    // Start requests while busy are ignored.
    step(1'b1, 3'd5, 1'b1);
    step(1'b1, 3'd0, 1'b1);
    step(1'b1, 3'd3, 1'b1);
    run_until_idle(40, 0);
    step(1'b0, 3'd0, 1'b1);

    // Reset after the second pop of stage 3, then stage 1 from a clean start.
    step(1'b1, 3'd3, 1'b1);
    for (int c = 0; c < 12 && pops_seen < 2; c++) step(1'b0, 3'd0, 1'b1);
    check_eq("pre_reset_pops", 64'(pops_seen), 64'd2);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check_reset_outputs("mid_rst");
    model_reset();
    repeat (2) @(negedge clk);
    release_reset();
    step(1'b1, 3'd1, 1'b1);
    run_until_idle(40, 0);
    step(1'b0, 3'd0, 1'b1);

    // Random traffic: random starts (including bad stages and while busy) and ready.
    for (int c = 0; c < 3000; c++) begin
      step(($urandom_range(0, 4) == 0), 3'($urandom_range(0, 7)), ($urandom_range(0, 2) != 0));
    end
    run_until_idle(200, 2);
    repeat (2) step(1'b0, 3'd0, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end
endmodule
